rv_inst_encoder: RTL
====================

Name: rv_inst_encoder

Overview:
- Encodes RV32I instruction requests (operation class, register fields, signed immediate) into 32-bit machine words.
- Writes each encoded word into instruction memory at an auto-incrementing word address.
- Inverse of the main control/immediate decode path: encodes exactly the subset that path decodes (ADD, ADDI, LW, SW, BEQ, BNE, BLT) plus NOP.
- Used by the bench/boot loader to build programs and to cross-check decode by round-trip.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- BASE_ADDR, 0, word address loaded on reset and on in_start.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_start  in  1  single-cycle pulse; reloads address to BASE_ADDR, clears wrapped
- in_op  in  3  0 ADD, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 BLT, 7 NOP
- in_rd  in  5  destination register
- in_rs1  in  5  source 1
- in_rs2  in  5  source 2
- in_imm  in  32  signed immediate (branch: byte offset)
- mem_we  out  1  write valid
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready
- mem_addr  out  ADDR_W  word address of the write
- mem_wdata  out  32  encoded instruction
- err  out  1  one-cycle pulse: last accepted request was illegal
- err_cnt  out  8  saturating count of illegal requests
- wrapped  out  1  sticky; address wrapped past all-ones

Behaviour:
- Reset (async): mem_we=0, mem_wdata=0, mem_addr=BASE_ADDR, err=0, err_cnt=0, wrapped=0. in_ready=1 immediately after reset.
- Single output register stage (states EMPTY/FULL, held by mem_we).
- in_ready = !mem_we || mem_ready, so a new request can be accepted in the same cycle the held word drains.
- Accept on cycle N → mem_we=1 with mem_wdata valid on cycle N+1. Latency is 1 cycle.
- mem_we, mem_addr and mem_wdata are held stable while mem_we && !mem_ready.
- Address increments by 1 on each completed write (mem_we && mem_ready).
  - Wrap: all-ones → 0 and sets wrapped.
- in_start:
  - Ignored while mem_we=1.
  - When mem_we=0: next mem_addr=BASE_ADDR and wrapped=0.
  - If in_start coincides with an accept, the accepted word is written at BASE_ADDR.
- Encodings (opcode / funct3 / funct7):
  - ADD: 0110011 / 000 / 0000000, R-type.
  - ADDI: 0010011 / 000, I-type, imm[11:0] in bits 31:20.
  - LW: 0000011 / 010, I-type.
  - SW: 0100011 / 010, S-type, imm[11:5] in 31:25, imm[4:0] in 11:7.
  - BEQ/BNE/BLT: 1100011 / 000/001/100, B-type: imm[12]→31, imm[10:5]→30:25, imm[4:1]→11:8, imm[11]→7.
  - NOP: 0x00000013; register and imm fields ignored.
  - Unused fields are zero: rs2 for I-type, rd for S/B-type.
- Legality:
  - I/S-type: imm in [-2048, 2047].
  - B-type: imm in [-4096, 4094] and imm[0]=0.
  - ADD and NOP are always legal.
- Illegal request:
  - It is still consumed (in_ready handshake completes).
  - Nothing is written: mem_we stays 0 on N+1 and the address does not advance.
  - err=1 for exactly cycle N+1; err_cnt increments, saturating at 255.
- A reset mid-write drops the pending word. No partial state survives.

Test Plan:
- ADDI x1,x0,5 with mem_ready=1 → cycle N+1: mem_we=1, mem_addr=0, mem_wdata=0x00500093.
- Back-to-back, in_valid held: LW x2,8(x1); SW x2,12(x1); ADD x3,x1,x2 → addrs 0,1,2; words 0x0080A103, 0x0020A623, 0x002081B3; in_ready stays 1 and there are no bubbles.
- BEQ x1,x2,-8 with mem_ready low for 3 cycles → 0xFE208CE3 held stable at addr 0 for 4 cycles. in_ready=0 while stalled. A second request is accepted in the cycle mem_ready rises.
- Illegal requests:
  - ADDI imm=2048 → no write; err pulse on N+1; err_cnt=1.
  - BNE imm=3 → err_cnt=2.
  - Address unchanged; next legal request writes at the unchanged address.
- ADDR_W=2: 5 NOPs → addrs 0,1,2,3,0; wrapped=1 after the 4th write. in_start → next NOP at addr 0 with wrapped=0.
- Assert reset while a word is held (mem_ready=0) → mem_we=0 and mem_addr=BASE_ADDR asynchronously. err_cnt=0 and in_ready=1 after release.

Source files
------------

// File: rtl/rv_inst_encoder.sv
// -----------------------------------------------------------------------------
// rv_inst_encoder
//
// Turns RV32I instruction requests (operation class, register numbers and a
// signed immediate) into 32-bit machine words and writes them to instruction
// memory at an auto-incrementing word address. Covers ADD, ADDI, LW, SW, BEQ,
// BNE, BLT and NOP. Requests whose immediate cannot be encoded are consumed
// but not written, and are flagged on err / err_cnt.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid && in_ready
//   in_start   one-cycle pulse: reload address to BASE_ADDR, clear wrapped
//   in_op      0 ADD, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 BLT, 7 NOP
//   in_rd      destination register
//   in_rs1     source register 1
//   in_rs2     source register 2
//   in_imm     signed immediate (byte offset for branches)
//   mem_we     write valid
//   mem_ready  memory accepts the write when mem_we && mem_ready
//   mem_addr   word address of the write
//   mem_wdata  encoded instruction
//   err        one-cycle pulse: last accepted request was illegal
//   err_cnt    saturating count of illegal requests
//   wrapped    sticky: address wrapped past all-ones
// -----------------------------------------------------------------------------
module rv_inst_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_start,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              wrapped
);

  localparam logic [ADDR_W-1:0] BASE_W   = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_BNE  = 3'd5;
  localparam logic [2:0] OP_BLT  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  // The output stage is either empty or holding one word for memory.
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  // 12-bit signed immediate range used by I- and S-type.
  function automatic logic imm_fits_12(input logic [31:0] imm);
    return ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
  endfunction

  // Branch offsets are 13-bit signed and must be even (bit 0 is not encoded).
  function automatic logic imm_fits_branch(input logic [31:0] imm);
    return ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094) &&
           (imm[0] == 1'b0);
  endfunction

  function automatic logic req_legal(input logic [2:0] op, input logic [31:0] imm);
    logic ok;
    case (op)
      OP_ADD, OP_NOP:         ok = 1'b1;
      OP_ADDI, OP_LW, OP_SW:  ok = imm_fits_12(imm);
      OP_BEQ, OP_BNE, OP_BLT: ok = imm_fits_branch(imm);
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(
    input logic [2:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    case (op)
      OP_ADD:  w = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_OP};
      OP_ADDI: w = {imm[11:0], rs1, 3'b000, rd, OPC_OP_IMM};
      OP_LW:   w = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
      OP_SW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
      OP_BEQ:  w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
      OP_BNE:  w = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], OPC_BRANCH};
      OP_BLT:  w = {imm[12], imm[10:5], rs2, rs1, 3'b100, imm[4:1], imm[11], OPC_BRANCH};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              wrapped_q, wrapped_d;

  logic accept_s;
  logic drain_s;
  logic legal_s;

  // A held word that drains this cycle frees the stage for a new request.
  assign in_ready = (state_q == ST_EMPTY) || mem_ready;
  assign accept_s = in_valid && in_ready;
  assign drain_s  = (state_q == ST_FULL) && mem_ready;
  assign legal_s  = req_legal(in_op, in_imm);

  // Next-state computation for the output stage, address and error status.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    wrapped_d   = wrapped_q;

    // mem_addr always names the slot of the held (or next) word, so it only
    // moves once a write completes; a restart is ignored while a word is held.
    if (drain_s) begin
      if (mem_addr_q == ADDR_MAX) begin
        mem_addr_d = {ADDR_W{1'b0}};
        wrapped_d  = 1'b1;
      end else begin
        mem_addr_d = mem_addr_q + ADDR_W'(1'b1);
      end
    end else if (in_start && (state_q == ST_EMPTY)) begin
      mem_addr_d = BASE_W;
      wrapped_d  = 1'b0;
    end else begin
      mem_addr_d = mem_addr_q;
    end

    if (accept_s) begin
      if (legal_s) begin
        state_d     = ST_FULL;
        mem_wdata_d = encode(in_op, in_rd, in_rs1, in_rs2, in_imm);
      end else begin
        // Illegal requests are consumed but never reach memory.
        state_d = ST_EMPTY;
        err_d   = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end
    end else if (drain_s) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // State registers with asynchronous reset; a pending word is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      mem_addr_q  <= BASE_W;
      mem_wdata_q <= 32'h0000_0000;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign mem_we    = (state_q == ST_FULL);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign wrapped   = wrapped_q;

endmodule
